// File: rtl/trigger_info_reader.sv
// Trigger-info FIFO reader: pops 128-bit records, emits two 64-bit readout beats each, tracks trigger-number continuity.
// Optional type filter enabled by defining TRIG_TYPE_FILTER_EN (adds type_mask input and drop_cnt output).
module trigger_info_reader #(
    parameter logic [7:0] HDR_TAG   = 8'hA5,
    parameter int         ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 event_count_reset,
    input  logic [127:0]         fifo_data,
    input  logic                 fifo_valid,
    output logic                 fifo_ready,
    output logic [63:0]          out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [31:0]          rec_cnt,
    output logic [ERR_CNT_W-1:0] seq_err_cnt,
`ifdef TRIG_TYPE_FILTER_EN
    input  logic [31:0]          type_mask,
    output logic [ERR_CNT_W-1:0] drop_cnt,
`endif
    output logic [2:0]           state
);

    // Handshakes: a FIFO word is consumed on a clock edge where fifo_valid & fifo_ready;
    // a readout beat is consumed on a clock edge where out_valid & out_ready. Beats hold while stalled.

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_BEAT0 = 3'b010,
        S_BEAT1 = 3'b100
    } state_t;

    state_t                state_q, state_d;
    logic                  fifo_ready_q, fifo_ready_d;
    logic [63:0]           out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [31:0]           rec_cnt_q, rec_cnt_d;
    logic [ERR_CNT_W-1:0]  seq_err_cnt_q, seq_err_cnt_d;
    logic [23:0]           expected_q, expected_d;
    logic [43:0]           ts_q, ts_d;
    logic [ERR_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [43:0]           rec_ts;
    logic [23:0]           rec_num;
    logic [4:0]            rec_type;
    logic                  seq_err;
    logic                  type_pass;
    logic                  pop;
    logic                  unused_hi_bits;

    assign rec_ts         = fifo_data[43:0];
    assign rec_num        = fifo_data[67:44];
    assign rec_type       = fifo_data[72:68];
    assign unused_hi_bits = ^fifo_data[127:73];
    assign seq_err        = (rec_num != expected_q);
    assign pop            = fifo_valid & fifo_ready_q;

`ifdef TRIG_TYPE_FILTER_EN
    assign type_pass = type_mask[rec_type];
    assign drop_cnt  = drop_cnt_q;
`else
    assign type_pass = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        rec_cnt_d     = rec_cnt_q;
        seq_err_cnt_d = seq_err_cnt_q;
        expected_d    = expected_q;
        ts_d          = ts_q;
        drop_cnt_d    = drop_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    rec_cnt_d  = rec_cnt_q + 32'd1;
                    expected_d = rec_num + 24'd1;
                    ts_d       = rec_ts;
                    if (seq_err && (seq_err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                        seq_err_cnt_d = seq_err_cnt_q + ERR_CNT_W'(1);
                    end
                    if (type_pass) begin
                        state_d     = S_BEAT0;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        out_data_d  = {HDR_TAG, seq_err, 2'b00, rec_type, 24'd0, rec_num};
                    end else if (drop_cnt_q != {ERR_CNT_W{1'b1}}) begin
                        drop_cnt_d = drop_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end
            S_BEAT0: begin
                if (out_ready) begin
                    state_d    = S_BEAT1;
                    out_data_d = {20'd0, ts_q};
                    out_last_d = 1'b1;
                end
            end
            S_BEAT1: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_data_d  = 64'd0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_data_d  = 64'd0;
            end
        endcase

        // A coincident pop compares against the old value above; the resync still wins here.
        if (event_count_reset) begin
            expected_d = 24'd1;
        end

        fifo_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fifo_ready_q  <= 1'b1;
            out_data_q    <= 64'd0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            rec_cnt_q     <= 32'd0;
            seq_err_cnt_q <= '0;
            expected_q    <= 24'd1;
            ts_q          <= 44'd0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fifo_ready_q  <= fifo_ready_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            rec_cnt_q     <= rec_cnt_d;
            seq_err_cnt_q <= seq_err_cnt_d;
            expected_q    <= expected_d;
            ts_q          <= ts_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign fifo_ready  = fifo_ready_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign rec_cnt     = rec_cnt_q;
    assign seq_err_cnt = seq_err_cnt_q;
    assign state       = state_q;

endmodule
